// File: rtl/unidade_controle_jogo_pkg.sv
// Shared state codes and defaults for the memory-game control unit.
// The debug 7-segment decoder imports the same codes.
package unidade_controle_jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    ESPERA_JOGADA = 4'h2,
    REGISTRA      = 4'h4,
    COMPARACAO    = 4'h5,
    PROXIMO       = 4'h6,
    FIM_ACERTOU   = 4'hA,
    FIM_TIMEOUT   = 4'hD,
    FIM_ERROU     = 4'hE
  } estado_t;

  localparam int TIMEOUT_CICLOS_PADRAO = 5000;
  localparam int TW_PADRAO             = 16;

  function automatic logic eh_fim(input estado_t e);
    return (e == FIM_ACERTOU) || (e == FIM_TIMEOUT) || (e == FIM_ERROU);
  endfunction

endpackage

// File: rtl/unidade_controle_jogo_contador_timeout.sv
// Per-move inactivity counter: sync clear, enable, saturating, with a
// terminal-count flag at LIMITE-1.
module contador_timeout #(
  parameter int TW     = 16,
  parameter int LIMITE = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_zera,
  input  logic i_conta,
  output logic o_fim
);

  localparam logic [TW-1:0] TC   = TW'(LIMITE - 1);
  localparam logic [TW-1:0] VMAX = '1;

  logic [TW-1:0] r_contagem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_contagem <= '0;
    else if (i_zera)
      r_contagem <= '0;
    else if (i_conta && (r_contagem != VMAX))
      r_contagem <= r_contagem + TW'(1);
  end

  assign o_fim = (r_contagem == TC);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore FSM sequencing the memory-game datapath, with a per-move timeout
// and hit / miss / timeout result flags.
//
// state         | meaning
// inicial       | idle, waiting for iniciar
// preparacao    | clear address counter and move register
// espera_jogada | waiting for a move, timeout window running
// registra      | load move register
// comparacao    | ROM data vs registered move
// proximo       | advance address counter
// fim_acertou   | all 16 moves matched
// fim_errou     | a move mismatched
// fim_timeout   | no move within the window
module unidade_controle_jogo
  import unidade_controle_jogo_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
  parameter int TW             = TW_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t r_estado;
  estado_t w_proximo;
  logic    w_fim_timeout;

  contador_timeout #(
    .TW     (TW),
    .LIMITE (TIMEOUT_CICLOS)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .i_zera  (r_estado != ESPERA_JOGADA),
    .i_conta (r_estado == ESPERA_JOGADA),
    .o_fim   (w_fim_timeout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_estado <= INICIAL;
    else
      r_estado <= w_proximo;
  end

  always_comb begin
    w_proximo = INICIAL;
    case (r_estado)
      INICIAL:       w_proximo = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:    w_proximo = ESPERA_JOGADA;
      // a move arriving in the expiry cycle still counts
      ESPERA_JOGADA: begin
        if (jogada_feita)       w_proximo = REGISTRA;
        else if (w_fim_timeout) w_proximo = FIM_TIMEOUT;
        else                    w_proximo = ESPERA_JOGADA;
      end
      REGISTRA:      w_proximo = COMPARACAO;
      COMPARACAO: begin
        if (!igual)     w_proximo = FIM_ERROU;
        else if (fimC)  w_proximo = FIM_ACERTOU;
        else            w_proximo = PROXIMO;
      end
      PROXIMO:       w_proximo = ESPERA_JOGADA;
      FIM_ACERTOU, FIM_TIMEOUT, FIM_ERROU:
                     w_proximo = iniciar ? PREPARACAO : r_estado;
      default:       w_proximo = INICIAL;
    endcase
  end

  always_comb begin
    zeraC     = 1'b0;
    contaC    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    pronto    = eh_fim(r_estado);
    case (r_estado)
      PREPARACAO: begin
        zeraC = 1'b1;
        zeraR = 1'b1;
      end
      REGISTRA:    registraR = 1'b1;
      PROXIMO:     contaC    = 1'b1;
      FIM_ACERTOU: acertou   = 1'b1;
      FIM_ERROU:   errou     = 1'b1;
      FIM_TIMEOUT: timeout   = 1'b1;
      default: ;
    endcase
  end

  assign db_estado = r_estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Bench for unidade_controle_jogo: vector table, directed corner sequences and
// randomized games checked against a trace built from the game rules.
module tb_unidade_controle_jogo;

  localparam int T = 8;

  logic clock = 1'b0;
  logic reset, iniciar, jogada_feita, igual, fimC;
  logic zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  unidade_controle_jogo #(.TIMEOUT_CICLOS(T), .TW(16)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
    .registraR(registraR), .pronto(pronto), .acertou(acertou), .errou(errou),
    .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  wire [7:0] w_saidas = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};

  typedef struct {
    logic       ini;
    logic       jf;
    logic       ig;
    logic       fc;
    logic [3:0] est;
  } passo_t;

  passo_t tab[14];
  passo_t trace[$];

  task automatic chk(input string nome, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
    end
  endtask

  // {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout} per state
  function automatic logic [7:0] saidas_esperadas(input logic [3:0] e);
    case (e)
      4'h1:    return 8'b1010_0000;
      4'h4:    return 8'b0001_0000;
      4'h6:    return 8'b0100_0000;
      4'hA:    return 8'b0000_1100;
      4'hE:    return 8'b0000_1010;
      4'hD:    return 8'b0000_1001;
      default: return 8'b0000_0000;
    endcase
  endfunction

  task automatic chk_estado(input string nome, input logic [3:0] e);
    chk($sformatf("%s_estado", nome), db_estado, e);
    chk($sformatf("%s_saidas", nome), w_saidas, saidas_esperadas(e));
  endtask

  task automatic set_in(input logic ini, input logic jf, input logic ig, input logic fc);
    iniciar = ini; jogada_feita = jf; igual = ig; fimC = fc;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Plays one game from inicial; move number `erro_em` (1-based) mismatches, 0 = none.
  task automatic jogar(input int erro_em, output int nc, output int nr);
    int cyc;
    nc = 0; nr = 0; cyc = 0;
    set_in(1, 0, 0, 0);
    tick();
    iniciar = 1'b0;
    while (!pronto && cyc < 400) begin
      if (contaC) nc++;
      if (registraR) nr++;
      jogada_feita = (db_estado == 4'h2) ? 1'b1 : 1'($urandom_range(0, 1));
      igual = (nr != erro_em);
      fimC  = (nc == 15);
      tick();
      cyc++;
    end
    chk("jogo_terminou", pronto, 1'b1);
  endtask

  initial begin
    int nc, nr, n;
    reset = 1'b1;
    set_in(0, 0, 0, 0);
    #12;
    reset = 1'b0;
    tick();

    // reset mid-espera
    set_in(1, 0, 0, 0);
    tick();
    iniciar = 1'b0;
    tick();
    chk_estado("pre_reset", 4'h2);
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk_estado("reset_async", 4'h0);
    chk("reset_contador", dut.u_timeout.r_contagem, 16'd0);
    @(negedge clock) reset = 1'b0;
    tick();
    chk_estado("pos_reset", 4'h0);

    // vector table, one edge per record
    tab[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1};
    tab[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h2};
    tab[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h2};
    tab[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h4};
    tab[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h5};
    tab[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h6};
    tab[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h2};
    tab[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h4};
    tab[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h5};
    tab[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hE};
    tab[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'hE};
    tab[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1};
    tab[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h2};
    for (int i = 0; i < 14; i++) begin
      set_in(tab[i].ini, tab[i].jf, tab[i].ig, tab[i].fc);
      tick();
      chk_estado($sformatf("tab%0d", i), tab[i].est);
    end

    // full correct game
    do_reset();
    jogar(0, nc, nr);
    chk("acerto_contaC", 16'(nc), 16'd15);
    chk("acerto_registraR", 16'(nr), 16'd16);
    chk_estado("acerto_fim", 4'hA);

    // miss on move 3, then hold
    do_reset();
    jogar(3, nc, nr);
    chk("erro_contaC", 16'(nc), 16'd2);
    chk_estado("erro_fim", 4'hE);
    set_in(0, 0, 0, 0);
    for (int i = 0; i < 50; i++) begin
      jogada_feita = 1'($urandom_range(0, 1));
      tick();
      chk_estado("erro_hold", 4'hE);
    end

    // restart from fim_errou
    set_in(1, 0, 0, 0);
    tick();
    chk_estado("reinicio_prep", 4'h1);
    iniciar = 1'b0;
    tick();
    chk_estado("reinicio_espera", 4'h2);
    chk("reinicio_contador", dut.u_timeout.r_contagem, 16'd0);

    // timeout window
    n = 0;
    while (db_estado == 4'h2 && n < 50) begin
      n++;
      tick();
    end
    chk("timeout_ciclos", 16'(n), 16'(T));
    chk_estado("timeout_fim", 4'hD);

    // move in the last cycle of the window wins
    set_in(1, 0, 0, 0);
    tick();
    iniciar = 1'b0;
    tick();
    for (int i = 1; i < T; i++) tick();
    chk_estado("ultimo_ciclo", 4'h2);
    jogada_feita = 1'b1;
    tick();
    jogada_feita = 1'b0;
    chk_estado("jogada_vence", 4'h4);

    // randomized games: expected state trace built from the game rules
    do_reset();
    trace.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    for (int g = 0; g < 6; g++) begin
      logic [3:0] fim;
      fim = 4'h0;
      trace.push_back('{1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 4'h1});
      for (int m = 0; m < 16 && fim == 4'h0; m++) begin
        bit esgota, ok;
        int w;
        esgota = ($urandom_range(0, 19) == 0);
        ok = ($urandom_range(0, 24) != 0);
        w = esgota ? T : $urandom_range(0, T - 1);
        for (int k = 0; k < w; k++)
          trace.push_back('{1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'h2});
        if (esgota) fim = 4'hD;
        else begin
          trace.push_back('{1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'h2});
          trace.push_back('{1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'h4});
          trace.push_back('{1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ok, (m == 15), 4'h5});
          if (!ok) fim = 4'hE;
          else if (m == 15) fim = 4'hA;
          else trace.push_back('{1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'h6});
        end
      end
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++)
        trace.push_back('{1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fim});
      trace.push_back('{(g != 5), 1'b0, 1'b0, 1'b0, fim});
    end
    foreach (trace[i]) begin
      chk_estado("rand", trace[i].est);
      set_in(trace[i].ini, trace[i].jf, trace[i].ig, trace[i].fc);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
